add64_seq: RTL and testbench
============================

ADD64_SEQ -- requirements
Module: add64_seq

Interface
REQ-001 Parameter: WORDS, default 4, number of 16-bit beats per operation; legal range 2..8.
REQ-002 Operand/result width is W = 16*WORDS bits, 64 at the default.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op_sub  input  1  0 = a+b, 1 = a-b; sampled at accept.
REQ-008 a, b  input  W each  operands; sampled at accept.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  W  result.
REQ-012 cout  output  1  carry out of the MSB beat; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  two's-complement signed overflow.
REQ-014 zero  output  1  sum == 0.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; no other states are reachable.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid=1, capture a, op_sub ? ~b : b, and op_sub; set beat=0 and carry=op_sub; go to BUSY.
REQ-017 BUSY: in_ready=0, out_valid=0; each cycle the shared 16-bit adder computes a_slice[beat] + b_slice[beat] + carry; the 16-bit result is written to sum[16*beat +: 16] and its carry-out to carry.
REQ-018 BUSY advances beat by 1 per cycle; on the cycle beat == WORDS-1 it goes to DONE and latches cout, ovf and zero.
REQ-019 Latency: out_valid rises exactly WORDS cycles after the accepting edge; WORDS = 4 gives 4.
REQ-020 ovf is the carry into the MSB XOR the carry out of the MSB, both taken from the final beat.
REQ-021 zero is 1 iff all W result bits are 0; it is computed from the registered sum slices plus the final slice.
REQ-022 DONE: out_valid=1, in_ready=0; sum and the flags are held stable while out_ready=0.
REQ-023 DONE with out_ready=1 goes to IDLE on the next edge; a new request is accepted no earlier than the following cycle.
REQ-024 Inputs a, b and op_sub are ignored outside the accepting cycle; changes during BUSY or DONE do not affect the result.
REQ-025 Arithmetic wraps modulo 2^W; no saturation.
REQ-026 Exactly one adder slice computes per cycle, and the adder is idle in IDLE and DONE.

Reset
REQ-027 rst=1 at a clock edge forces IDLE, beat=0, carry=0, sum=0, cout=0, ovf=0, zero=0, out_valid=0.
REQ-028 After reset, in_ready=1 in the first cycle.
REQ-029 Reset during BUSY or DONE aborts the operation; no out_valid is produced for it.
REQ-030 Reset has priority over any simultaneous in_valid or out_ready.

Structure
REQ-031 Shared package: the FSM state encoding (IDLE/BUSY/DONE), the beat width constant (16), and the beat-index width constant.
REQ-032 One sub-module: the existing 16-bit carry-lookahead adder add16_cla, instantiated once as the shared slice datapath.
REQ-033 Operand slicing and the sum write-back are done with a beat-indexed mux and register; no generate-replicated adders.

Verification
REQ-034 a=0x0000_0000_0000_FFFF, b=1, op_sub=0 -> after 4 cycles sum=0x0000_0000_0001_0000, cout=0, ovf=0, zero=0.
REQ-035 a=0xFFFF_FFFF_FFFF_FFFF, b=1, add -> sum=0, cout=1, zero=1, ovf=0; carry ripples through all 4 beats.
REQ-036 a=0x7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
REQ-037 a=5, b=7, op_sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), ovf=0.
REQ-038 Hold out_ready=0 for 10 cycles in DONE -> out_valid, sum and flags stay stable and in_ready=0; a new request presented during this time is not accepted.
REQ-039 Assert rst in beat 2 of BUSY -> next cycle IDLE with all outputs 0 and in_ready=1; a following request for 3+4 yields sum=7.

Source files
------------

// File: rtl/add64_seq_pkg.sv
// Shared definitions for the beat-serial add/subtract unit: FSM encoding and beat geometry.
package add64_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BEAT_W     = 16;
  // Wide enough to index up to 8 beats, the largest supported operand size.
  localparam int BEAT_IDX_W = 3;

endpackage

// File: rtl/add64_seq_add16_cla.sv
// 16-bit carry-lookahead adder slice; 4-bit groups with lookahead group carries.
module add16_cla
  import add64_seq_pkg::*;
(
  input  logic [BEAT_W-1:0] a,
  input  logic [BEAT_W-1:0] b,
  input  logic              cin,
  output logic [BEAT_W-1:0] s,
  output logic              c_msb,
  output logic              cout
);

  logic [BEAT_W-1:0] g;
  logic [BEAT_W-1:0] p;
  logic [BEAT_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic gg;
    logic pg;
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < BEAT_W / 4; k++) begin
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg = &p[4*k +: 4];
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
      // Group carry-out skips the in-group chain.
      c[4*k+4] = gg | (pg & c[4*k]);
    end
  end

  assign s     = p ^ c[BEAT_W-1:0];
  assign c_msb = c[BEAT_W-1];
  assign cout  = c[BEAT_W];

endmodule

// File: rtl/add64_seq.sv
// Beat-serial W-bit add/subtract: one shared 16-bit CLA slice computes one beat per cycle.
module add64_seq
  import add64_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op_sub,
  input  logic [BEAT_W*WORDS-1:0] a,
  input  logic [BEAT_W*WORDS-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BEAT_W*WORDS-1:0] sum,
  output logic                    cout,
  output logic                    ovf,
  output logic                    zero
);

  localparam int W = BEAT_W * WORDS;

  state_t                state;
  state_t                state_nxt;
  logic [BEAT_IDX_W-1:0] beat;
  logic                  carry;
  logic [W-1:0]          a_q;
  logic [W-1:0]          b_q;
  logic [W-1:0]          sum_nxt;
  logic [BEAT_W-1:0]     a_sl;
  logic [BEAT_W-1:0]     b_sl;
  logic [BEAT_W-1:0]     s_sl;
  logic                  cin_sl;
  logic                  c_msb;
  logic                  c_out;
  logic                  busy;
  logic                  last_beat;

  assign busy      = (state == BUSY);
  assign last_beat = (beat == BEAT_IDX_W'(WORDS - 1));

  // Operand isolation keeps the slice quiet outside BUSY.
  always_comb begin
    a_sl    = '0;
    b_sl    = '0;
    cin_sl  = busy & carry;
    sum_nxt = sum;
    if (busy) begin
      for (int i = 0; i < WORDS; i++) begin
        if (beat == BEAT_IDX_W'(i)) begin
          a_sl = a_q[i*BEAT_W +: BEAT_W];
          b_sl = b_q[i*BEAT_W +: BEAT_W];
          sum_nxt[i*BEAT_W +: BEAT_W] = s_sl;
        end
      end
    end
  end

  add16_cla u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (cin_sl),
    .s    (s_sl),
    .c_msb(c_msb),
    .cout (c_out)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture; subtraction is a + ~b + 1 with the +1 injected as the initial carry.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= op_sub ? ~b : b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat  <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            beat  <= '0;
            carry <= op_sub;
          end
        end
        BUSY: begin
          sum   <= sum_nxt;
          carry <= c_out;
          if (last_beat) begin
            beat <= '0;
            cout <= c_out;
            ovf  <= c_msb ^ c_out;
            zero <= (sum_nxt == '0);
          end else begin
            beat <= beat + BEAT_IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add64_seq.sv
// Scoreboard bench for add64_seq at WORDS=4.
module tb_add64_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  exp_t sb[$];

  add64_seq #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic sub);
    logic [W:0]   full;
    logic [W-1:0] yb;
    exp_t         e;
    yb   = sub ? ~y : y;
    full = {1'b0, x} + {1'b0, yb} + (W+1)'(sub);
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.o  = (x[W-1] == yb[W-1]) && (e.s[W-1] != x[W-1]);
    e.z  = (e.s == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Presents one request; afterwards the bench sits one cycle past the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                      input exp_t e, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
      return;
    end
    a        = x;
    b        = y;
    op_sub   = sub;
    in_valid = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = rnd64();
    b        = rnd64();
    op_sub   = $urandom_range(0, 1) != 0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    op_sub    = 1'b0;
    a         = 64'd3;
    b         = 64'd4;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
    end
    checks++;
    if ({sum, cout, ovf, zero} !== '0) begin
      failures++;
      $display("FAIL reset_outputs sum=%h c=%0b o=%0b z=%0b exp all 0", sum, cout, ovf, zero);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [4] = '{64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'h7FFF_FFFF_FFFF_FFFF, 64'd5};
    logic [W-1:0] vb [4] = '{64'd1, 64'd1, 64'd1, 64'd7};
    logic         vs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] es [4] = '{64'h0000_0000_0001_0000, 64'h0,
                             64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE};
    logic [2:0]   ef [4] = '{3'b000, 3'b101, 3'b010, 3'b000};
    exp_t         e;
    exp_t         got;
    int           lat;
    for (int i = 0; i < 4; i++) begin
      e = '{s: es[i], c: ef[i][2], o: ef[i][1], z: ef[i][0]};
      send(va[i], vb[i], vs[i], e, 1'b1);
      wait_out(lat);
      checks++;
      if (lat !== WORDS) begin
        failures++;
        $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, WORDS);
      end
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL vec%0d_scoreboard_empty got=0 entries exp=1", i);
      end else begin
        got = sb.pop_front();
        checks++;
        if (sum !== got.s) begin
          failures++;
          $display("FAIL vec%0d_sum got=%h exp=%h", i, sum, got.s);
        end
        checks++;
        if ({cout, ovf, zero} !== {got.c, got.o, got.z}) begin
          failures++;
          $display("FAIL vec%0d_flags got c/o/z=%0b%0b%0b exp=%0b%0b%0b",
                   i, cout, ovf, zero, got.c, got.o, got.z);
        end
      end
      release_out();
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int   lat;
    int   bad;
    e = model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0);
    send(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, e, 1'b1);
    wait_out(lat);
    in_valid = 1'b1;
    a        = 64'd9;
    b        = 64'd9;
    bad      = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a = rnd64();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e.s ||
          {cout, ovf, zero} !== {e.c, e.o, e.z}) begin
        failures++;
        bad++;
        $display("FAIL hold_cycle%0d out_valid=%0b in_ready=%0b sum=%h exp_sum=%h", i,
                 out_valid, in_ready, sum, e.s);
      end
    end
    in_valid = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release in_ready=%0b out_valid=%0b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    exp_t got;
    int   lat;
    int   seen;
    e = model(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
    send(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, e, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {sum, cout, ovf, zero} !== '0) begin
      failures++;
      $display("FAIL abort_state in_ready=%0b out_valid=%0b sum=%h c/o/z=%0b%0b%0b exp 1/0/0",
               in_ready, out_valid, sum, cout, ovf, zero);
    end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_output got=%0d valid cycles exp=0", seen);
    end
    send(64'd3, 64'd4, 1'b0, model(64'd3, 64'd4, 1'b0), 1'b1);
    wait_out(lat);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL abort_followup_scoreboard_empty got=0 entries exp=1");
    end else begin
      got = sb.pop_front();
      if (sum !== got.s || sum !== 64'd7) begin
        failures++;
        $display("FAIL abort_followup_sum got=%h exp=%h", sum, got.s);
      end
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         s;
    exp_t         got;
    int           lat;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      x = rnd64();
      y = (i % 4 == 3) ? x : rnd64();
      s = (i % 2 == 1);
      if (i == 4) begin
        x = 64'h8000_0000_0000_0000;
        y = 64'd1;
        s = 1'b1;
      end
      send(x, y, s, model(x, y, s), 1'b1);
      wait_out(lat);
      checks++;
      if (lat !== WORDS || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b%0d_handshake lat=%0d in_ready=%0b exp lat=%0d in_ready=0",
                 i, lat, in_ready, WORDS);
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL b2b%0d_scoreboard_empty got=0 entries exp=1", i);
      end else begin
        got = sb.pop_front();
        if (sum !== got.s || {cout, ovf, zero} !== {got.c, got.o, got.z}) begin
          failures++;
          $display("FAIL b2b%0d_result got=%h c/o/z=%0b%0b%0b exp=%h %0b%0b%0b",
                   i, sum, cout, ovf, zero, got.s, got.c, got.o, got.z);
        end
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
